// File: rtl/seven_seg_scanner_if.sv
// Signal bundle between the display-value producer and the seven-segment scanner.
// The producer drives the frame data; the scanner drives the board pins.
interface seven_seg_scanner_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    load;
  logic [4*NUM_DIGITS-1:0] hexVals;
  logic [NUM_DIGITS-1:0]   dpIn;
  logic [NUM_DIGITS-1:0]   blankEn;
  logic                    lzSuppress;
  logic [NUM_DIGITS-1:0]   anode;
  logic [7:0]              cathode;
  logic                    frameStart;

  modport master (
    output load, hexVals, dpIn, blankEn, lzSuppress,
    input  anode, cathode, frameStart
  );

  modport slave (
    input  load, hexVals, dpIn, blankEn, lzSuppress,
    output anode, cathode, frameStart
  );
endinterface

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed common-anode seven-segment driver with a double-buffered frame,
// per-slot anti-ghosting blank window and optional leading-zero suppression.
module seven_seg_scanner #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  seven_seg_scanner_if.slave bus
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int HEX_W = 4 * NUM_DIGITS;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] ALL_ONES = {NUM_DIGITS{1'b1}};
  localparam logic [NUM_DIGITS-1:0] ALL_ZERO = {NUM_DIGITS{1'b0}};

  // Active-low segment pattern g..a for one hex nibble.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      4'hF:    seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

  logic [CNT_W-1:0]      cnt_r;
  logic [IDX_W-1:0]      idx_r;
  logic [HEX_W-1:0]      act_hex_r;
  logic [NUM_DIGITS-1:0] act_dp_r;
  logic [NUM_DIGITS-1:0] act_blank_r;
  logic [HEX_W-1:0]      pend_hex_r;
  logic [NUM_DIGITS-1:0] pend_dp_r;
  logic [NUM_DIGITS-1:0] pend_blank_r;
  logic                  pend_valid_r;
  logic [NUM_DIGITS-1:0] anode_r;
  logic [7:0]            cathode_r;
  logic                  frame_start_r;

  logic                  slot_end_s;
  logic                  frame_end_s;
  logic                  blank_win_s;
  logic [NUM_DIGITS-1:0] zero_s;
  logic [NUM_DIGITS-1:0] lead_s;
  logic [NUM_DIGITS-1:0] suppress_s;
  logic [NUM_DIGITS-1:0] sel_s;
  logic [3:0]            cur_hex_s;
  logic                  cur_dp_s;
  logic                  cur_dark_s;
  logic [NUM_DIGITS-1:0] anode_nxt_s;
  logic [7:0]            cathode_nxt_s;

  assign slot_end_s  = (cnt_r == CNT_LAST);
  assign frame_end_s = slot_end_s && (idx_r == IDX_LAST);

  // With no blank window the comparison would be constant, so it is not built at all.
  generate
    if (BLANK_CYCLES > 0) begin : g_blank
      assign blank_win_s = (cnt_r < CNT_W'(BLANK_CYCLES));
    end else begin : g_no_blank
      assign blank_win_s = 1'b0;
    end
  endgenerate

  // Slot counter and digit index.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= {CNT_W{1'b0}};
      idx_r <= {IDX_W{1'b0}};
    end else if (slot_end_s) begin
      cnt_r <= {CNT_W{1'b0}};
      idx_r <= (idx_r == IDX_LAST) ? {IDX_W{1'b0}} : idx_r + IDX_W'(1);
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
      idx_r <= idx_r;
    end
  end

  // Pending/active frame buffers; the swap uses the pre-edge pending contents,
  // so a load on the boundary edge itself waits for the following frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      act_hex_r    <= {HEX_W{1'b0}};
      act_dp_r     <= ALL_ZERO;
      act_blank_r  <= ALL_ZERO;
      pend_hex_r   <= {HEX_W{1'b0}};
      pend_dp_r    <= ALL_ZERO;
      pend_blank_r <= ALL_ZERO;
      pend_valid_r <= 1'b0;
    end else begin
      if (frame_end_s && pend_valid_r) begin
        act_hex_r   <= pend_hex_r;
        act_dp_r    <= pend_dp_r;
        act_blank_r <= pend_blank_r;
      end
      if (bus.load) begin
        pend_hex_r   <= bus.hexVals;
        pend_dp_r    <= bus.dpIn;
        pend_blank_r <= bus.blankEn;
        pend_valid_r <= 1'b1;
      end else if (frame_end_s) begin
        pend_valid_r <= 1'b0;
      end
    end
  end

  // Leading-zero scan: a digit is suppressed while it and everything above it reads as zero.
  always_comb begin
    zero_s     = ALL_ZERO;
    lead_s     = ALL_ZERO;
    suppress_s = ALL_ZERO;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      zero_s[i] = act_blank_r[i] | ((act_hex_r[4*i +: 4] == 4'h0) & ~act_dp_r[i]);
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      lead_s[i] = ((zero_s >> i) == (ALL_ONES >> i));
    end
    if (bus.lzSuppress) begin
      suppress_s = lead_s;
    end else begin
      suppress_s = ALL_ZERO;
    end
    suppress_s[0] = 1'b0;
  end

  // Select the digit currently being scanned.
  always_comb begin
    sel_s      = ALL_ZERO;
    cur_hex_s  = 4'h0;
    cur_dp_s   = 1'b0;
    cur_dark_s = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_r == IDX_W'(i)) begin
        sel_s[i]   = 1'b1;
        cur_hex_s  = act_hex_r[4*i +: 4];
        cur_dp_s   = act_dp_r[i];
        cur_dark_s = act_blank_r[i] | suppress_s[i];
      end else begin
        sel_s[i] = 1'b0;
      end
    end
  end

  // Next pin values; a dark digit still gets its anode so slot timing stays uniform.
  always_comb begin
    anode_nxt_s   = ALL_ONES;
    cathode_nxt_s = 8'hFF;
    if (blank_win_s) begin
      anode_nxt_s   = ALL_ONES;
      cathode_nxt_s = 8'hFF;
    end else if (cur_dark_s) begin
      anode_nxt_s   = ~sel_s;
      cathode_nxt_s = 8'hFF;
    end else begin
      anode_nxt_s   = ~sel_s;
      cathode_nxt_s = {~cur_dp_s, seg_decode(cur_hex_s)};
    end
  end

  // Registered pin drivers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      anode_r       <= ALL_ONES;
      cathode_r     <= 8'hFF;
      frame_start_r <= 1'b0;
    end else begin
      anode_r       <= anode_nxt_s;
      cathode_r     <= cathode_nxt_s;
      frame_start_r <= frame_end_s;
    end
  end

  assign bus.anode      = anode_r;
  assign bus.cathode    = cathode_r;
  assign bus.frameStart = frame_start_r;

endmodule
